// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multi-cycle multiply/divide controller owning architectural HI/LO
// The result is computed at the start edge and held in pending registers until the latency counter expires.
module md_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);

  state_t      state, state_n;
  logic [4:0]  count, count_n;
  logic [31:0] pend_hi, pend_hi_n;
  logic [31:0] pend_lo, pend_lo_n;
  logic [31:0] hi_n, lo_n;

  logic [63:0] mul_a, mul_b, mul_p;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic        is_md_op;

  // Multiply on 64-bit extended operands; the low 64 bits equal the signed or unsigned product.
  always_comb begin
    if (md_op == OP_MULT) begin
      mul_a = {{32{rs_val[31]}}, rs_val};
      mul_b = {{32{rt_val[31]}}, rt_val};
    end else begin
      mul_a = {32'd0, rs_val};
      mul_b = {32'd0, rt_val};
    end
    mul_p = mul_a * mul_b;
  end

  // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN with no special case.
  always_comb begin
    div_signed = (md_op == OP_DIV);
    a_neg      = div_signed & rs_val[31];
    b_neg      = div_signed & rt_val[31];
    a_mag      = a_neg ? (~rs_val + 32'd1) : rs_val;
    b_mag      = b_neg ? (~rt_val + 32'd1) : rt_val;
    b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    if (rt_val == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = rs_val;
    end
  end

  assign is_md_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign busy     = (state == BUSY);
  assign stall    = md_use_d & (busy | (md_start & is_md_op));

  always_comb begin
    state_n   = state;
    count_n   = count;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    hi_n      = hi;
    lo_n      = lo;
    case (state)
      IDLE: begin
        if (md_start && !flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_n = mul_p[63:32];
              pend_lo_n = mul_p[31:0];
              count_n   = MUL_LOAD;
              state_n   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_n = rem;
              pend_lo_n = quo;
              count_n   = DIV_LOAD;
              state_n   = BUSY;
            end
            OP_MTHI: hi_n = rs_val;
            OP_MTLO: lo_n = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (flush) begin
          state_n   = IDLE;
          count_n   = 5'd0;
          pend_hi_n = 32'd0;
          pend_lo_n = 32'd0;
        end else if (count == 5'd1) begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          state_n = IDLE;
          count_n = 5'd0;
        end else begin
          count_n = count - 5'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 5'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;

  md_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .md_op(md_op), .md_start(md_start),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .md_use_d(md_use_d),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && busy && md_start) proto_viol++;
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    nb = 0;
    while (busy && nb < 64) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; md_op = 3'd0; md_start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    flush = 1'b0; md_use_d = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset_n = 1'b1;
    md_use_d = 1'b0;
  endtask

  task automatic test_mult();
    int nb;
    do_op(3'd1, 32'hFFFFFFFE, 32'd3, nb);
    checks++; if (nb !== 5) begin errors++; $display("FAIL mult_busy got %0d want 5", nb); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    do_op(3'd2, 32'hFFFFFFFE, 32'd3, nb);
    checks++; if (nb !== 5) begin errors++; $display("FAIL multu_busy got %0d want 5", nb); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL multu_hi got %h want 00000002", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", lo); end
  endtask

  task automatic test_div();
    int nb;
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, nb);
    checks++; if (nb !== 10) begin errors++; $display("FAIL div_busy got %0d want 10", nb); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    do_op(3'd3, 32'd7, 32'hFFFFFFFE, nb);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdivisor_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negdivisor_hi got %h want 00000001", hi); end
    do_op(3'd4, 32'd7, 32'd0, nb);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divu_zero_hi got %h want 00000007", hi); end
    do_op(3'd3, 32'hFFFFFFFB, 32'd0, nb);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL div_zero_hi got %h want fffffffb", hi); end
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, nb);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, nb);
    checks++; if (lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got %h want 7ffffffc", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 00000001", hi); end
  endtask

  task automatic test_mtxx();
    logic [31:0] lo_before, hi_before;
    lo_before = lo;
    @(negedge clk);
    md_op = 3'd5; rs_val = 32'h12345678; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    checks++; if (lo !== lo_before) begin errors++; $display("FAIL mthi_lo got %h want %h", lo, lo_before); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    hi_before = hi;
    md_op = 3'd6; rs_val = 32'h9ABCDEF0; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo); end
    checks++; if (hi !== hi_before) begin errors++; $display("FAIL mtlo_hi got %h want %h", hi, hi_before); end
    md_op = 3'd7; rs_val = 32'hDEADBEEF; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0) begin
      errors++; $display("FAIL op7_noop got hi=%h lo=%h busy=%b want 12345678 9abcdef0 0", hi, lo, busy);
    end
  endtask

  task automatic test_stall();
    int bad;
    md_use_d = 1'b1;
    @(negedge clk);
    md_op = 3'd1; rs_val = 32'd4; rt_val = 32'd5; md_start = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start got %b want 1", stall); end
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_busy got %0d low cycles want 0", bad); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after got %b want 0", stall); end
    checks++; if (lo !== 32'd20) begin errors++; $display("FAIL stall_mult_lo got %h want 00000014", lo); end
    md_use_d = 1'b0;
    @(negedge clk);
    md_op = 3'd1; md_start = 1'b1;
    bad = 0;
    #1; if (stall !== 1'b0) bad++;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 7; i++) begin
      #1; if (stall !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_nouse got %0d high cycles want 0", bad); end
  endtask

  task automatic test_flush();
    logic [31:0] h0, l0;
    int n;
    h0 = hi; l0 = lo;
    @(negedge clk);
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    repeat (12) @(negedge clk);
    checks++; if (hi !== h0 || lo !== l0) begin
      errors++; $display("FAIL flush_hilo got %h/%h want %h/%h", hi, lo, h0, l0);
    end
    md_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9; md_start = 1'b1; flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", busy); end
    md_op = 3'd5; rs_val = 32'hCAFEF00D; md_start = 1'b1; flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0; flush = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (hi !== h0 || lo !== l0) begin
      errors++; $display("FAIL flush_start_hilo got %h/%h want %h/%h", hi, lo, h0, l0);
    end
    md_op = 3'd4; rs_val = 32'd50; rt_val = 32'd3; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
      errors++; $display("FAIL flush_complete got busy=%b %h/%h want 0 %h/%h", busy, hi, lo, h0, l0);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    @(negedge clk);
    md_op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b %h/%h want 0 0/0", busy, hi, lo);
    end
    #1 reset_n = 1'b1;
    do_op(3'd1, 32'd7, 32'd6, nb);
    checks++; if (nb !== 5 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL reset_mid_mult got n=%0d %h/%h want 5 0/2a", nb, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL b2b_multu got %h/%h want fffffffe/00000001", hi, lo);
    end
    do_op(3'd4, 32'd100, 32'd7, nb);
    checks++; if (nb !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL b2b_divu got n=%0d %h/%h want 10 2/e", nb, hi, lo);
    end
  endtask

  task automatic test_protocol();
    checks++; if (proto_viol !== 0) begin
      errors++; $display("FAIL protocol_start_while_busy got %0d want 0", proto_viol);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtxx();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, computes operands internally, and commits the result to the architectural HI/LO after a fixed per-op latency.
- Drives the busy/stall signal that freezes D-stage HI/LO-dependent instructions (md ops, MFHI, MFLO) until the unit frees.
- Owns HI/LO; the E-stage forwarding mux reads hi/lo directly.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1-31)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1-31)

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
md_op  input  3  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
md_start  input  1  E-stage instruction valid and md_op meaningful this cycle
rs_val  input  32  forwarded rs operand (dividend / multiplicand / MTxx source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
flush  input  1  exception/eret flush; aborts any in-flight op
md_use_d  input  1  D-stage instruction is an md op or MFHI/MFLO
busy  output  1  multi-cycle op in flight
stall  output  1  freeze F/D, bubble into E
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset_n low, immediate, independent of clk): state IDLE, counter 0, hi=0, lo=0, busy=0, pending result cleared. stall is therefore 0 whenever md_start=0.
- States: IDLE, BUSY.
- IDLE:
  - md_start with op 1-4 at edge t: latch the full 64-bit result into pending_hi/pending_lo, load counter with MUL_CYCLES or DIV_CYCLES, go to BUSY.
  - md_start with op 5/6: write hi/lo from rs_val at edge t; stay IDLE.
  - op 0/7: no action.
- BUSY:
  - busy=1; counter decrements each edge.
  - At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, go to IDLE, busy falls.
  - busy is high for exactly N cycles following the start edge; new HI/LO are visible the cycle after the last busy cycle.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}=product.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - DIVU: unsigned.
  - Divide by zero (rt_val==0): lo=32'hFFFFFFFF, hi=rs_val, for both DIV and DIVU.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- stall = md_use_d & (busy | (md_start & md_op in 1..4)). Combinational; covers the start cycle itself.
- md_start while BUSY: ignored, no state change. The pipeline guarantees this cannot occur; the bench asserts it never happens.
- flush:
  - Flush while BUSY: abort, go to IDLE next edge, hi/lo unchanged, pending discarded.
  - Flush with md_start in the same cycle: start ignored, MTxx not written.
  - Flush on the completion edge (counter==1): flush wins, hi/lo unchanged.
- Reset mid-operation: immediate return to the reset state; pending result lost.

Test Plan:
- MULT rs=32'hFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; MULTU with the same operands -> hi=2, lo=32'hFFFFFFFA.
- DIV rs=-7 (32'hFFFFFFF9), rt=2 -> busy 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7; DIV 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
- MTHI rs=32'h12345678 in IDLE -> hi=32'h12345678 one edge later, busy stays 0; MTLO likewise updates lo only.
- md_use_d held high during MULT start and busy -> stall=1 on the start cycle and all 5 busy cycles, 0 on the following cycle; md_use_d=0 -> stall=0 throughout.
- DIV started, flush at busy cycle 4 -> busy drops next edge, hi/lo keep their prior values; flush coincident with a MULT start -> no busy, hi/lo unchanged; flush on the completion edge -> hi/lo unchanged.
- reset_n pulsed low mid-DIV, between clock edges -> busy, hi, lo go to 0 immediately without a clock edge; a following MULT behaves normally.
